// File: rtl/pattern_pkg.sv
// Shared definitions for the 101 serial pattern transmitter and its detector.
package pattern_pkg;

    // Transmitter FSM states
    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    // Pattern being detected, oldest bit in the MSB
    localparam int                 PAT_LEN = 3;
    localparam logic [PAT_LEN-1:0] PATTERN = 3'b101;

endpackage

// File: rtl/pattern_golden_model.sv
// Golden Moore-style 101 detector watching the transmitted bit stream.
// It keeps a short history of emitted bits, raises expect_y the cycle after
// a pattern completes, and counts overlapping matches with saturation.
module pattern_golden_model
    import pattern_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_bit,
    output logic             expect_y,
    output logic [CNT_W-1:0] match_cnt
);

    logic [PAT_LEN-2:0] hist_q;
    logic [PAT_LEN-2:0] hist_d;
    logic               expect_y_q;
    logic [CNT_W-1:0]   match_cnt_q;
    logic [CNT_W-1:0]   match_cnt_d;
    logic [PAT_LEN-1:0] window;
    logic               hit;

    // Compare the history plus the current bit against the pattern, shift the history, bump the count
    always_comb begin
        window      = {hist_q, tx_bit};
        hit         = (window == PATTERN);
        hist_d      = window[PAT_LEN-2:0];
        match_cnt_d = match_cnt_q;
        if (hit && (match_cnt_q != {CNT_W{1'b1}})) begin
            match_cnt_d = match_cnt_q + CNT_W'(1);
        end
    end

    // History shifts every cycle, idle zeros included, so gaps break patterns as a real detector sees them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q      <= '0;
            expect_y_q  <= 1'b0;
            match_cnt_q <= '0;
        end else begin
            hist_q      <= hist_d;
            expect_y_q  <= hit;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign expect_y  = expect_y_q;
    assign match_cnt = match_cnt_q;

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial transmitter: accepts parallel words on a valid/ready handshake and
// shifts them out MSB first, one bit per clock, with gapless back-to-back
// streaming. A golden 101 detector runs alongside on the emitted stream.
module serial_pattern_tx
    import pattern_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             tx_bit,
    output logic             tx_active,
    output logic             frame_done,
    output logic             expect_y,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int             BCW      = $clog2(WIDTH);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [BCW-1:0]   bit_cnt_q;
    logic [BCW-1:0]   bit_cnt_d;
    logic             last_bit;
    logic             accept;

    // All outputs decode from flops only. The shift register drains to zero after
    // the LSB, so its MSB is 0 whenever the FSM sits in IDLE.
    assign last_bit   = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT);
    assign in_ready   = (state_q == IDLE) || last_bit;
    assign accept     = in_valid && in_ready;
    assign tx_bit     = shreg_q[WIDTH-1];
    assign tx_active  = (state_q == SHIFT);
    assign frame_done = last_bit;

    // Next-state logic: shift while in a frame, leave after the LSB, and let an accept override for a fresh load
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
            end
            SHIFT: begin
                shreg_d   = shreg_q << 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (last_bit) begin
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (accept) begin
            state_d   = SHIFT;
            shreg_d   = in_data;
            bit_cnt_d = '0;
        end
    end

    // State, shift register and bit counter; reset discards any partial word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    pattern_golden_model #(
        .CNT_W(CNT_W)
    ) u_golden (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_bit   (tx_bit),
        .expect_y (expect_y),
        .match_cnt(match_cnt)
    );

endmodule
